// File: rtl/mux3_to_1_pkg.sv
// ----------------------------------------------------------------------------
// mux3_to_1_pkg
// Shared constants and types for the registered 3-input selector.
//   SEL_D0/SEL_D1/SEL_D2 : legal select codes choosing d0/d1/d2
//   SEL_BAD              : the one illegal code, decoded to an all-zero result
//   sel_t                : 2-bit select type
//   DEF_WIDTH            : default data width
// ----------------------------------------------------------------------------
package mux3_to_1_pkg;

   typedef logic [1:0] sel_t;

   localparam sel_t SEL_D0  = 2'd0;
   localparam sel_t SEL_D1  = 2'd1;
   localparam sel_t SEL_D2  = 2'd2;
   localparam sel_t SEL_BAD = 2'd3;

   localparam int DEF_WIDTH = 16;

   // True when the code is the illegal select value.
   function automatic logic sel_is_bad(input sel_t sel);
      return (sel == SEL_BAD);
   endfunction

endpackage

// File: rtl/mux3_to_1_sel.sv
// ----------------------------------------------------------------------------
// mux3_to_1_sel
// Purely combinational decode of d0/d1/d2 by sel into the next y value.
// Ports:
//   d0, d1, d2 : WIDTH-bit data candidates
//   sel        : 2-bit source select (3 is illegal)
//   y_nxt      : selected data; all zeros for the illegal select
// ----------------------------------------------------------------------------
module mux3_to_1_sel
   import mux3_to_1_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  sel_t             sel,
   output logic [WIDTH-1:0] y_nxt
);

   // Full-case select decode; the illegal code maps to a deterministic zero.
   always_comb begin
      y_nxt = {WIDTH{1'b0}};
      case (sel)
         SEL_D0:  y_nxt = d0;
         SEL_D1:  y_nxt = d1;
         SEL_D2:  y_nxt = d2;
         SEL_BAD: y_nxt = {WIDTH{1'b0}};
         default: y_nxt = {WIDTH{1'b0}};
      endcase
   end

endmodule

// File: rtl/mux3_to_1.sv
// ----------------------------------------------------------------------------
// mux3_to_1
// Registered 3-input selector for datapath forwarding / writeback selection.
// One-cycle latency, accepts a new selection every cycle, no backpressure.
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset (clears y and out_valid)
//   in_valid  : qualifies d0/d1/d2/sel this cycle
//   d0/d1/d2  : WIDTH-bit data sources for sel = 0/1/2
//   sel       : 2-bit select, 3 is illegal and yields y = 0
//   y         : registered selected data, held while in_valid is low
//   out_valid : y was captured on the previous in_valid edge
// Optional (macro MUX3_TO_1_SELERR_EN):
//   sel_err   : sticky flag, set by any valid sample with sel = 3
//   err_cnt   : 8-bit saturating count of those events
// ----------------------------------------------------------------------------
module mux3_to_1
   import mux3_to_1_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  sel_t             sel,
   output logic [WIDTH-1:0] y,
   output logic             out_valid
`ifdef MUX3_TO_1_SELERR_EN
   ,
   output logic             sel_err,
   output logic [7:0]       err_cnt
`endif
);

   logic [WIDTH-1:0] y_nxt_s;
   logic [WIDTH-1:0] y_r;
   logic             out_valid_r;

   mux3_to_1_sel #(
      .WIDTH (WIDTH)
   ) u_sel (
      .d0    (d0),
      .d1    (d1),
      .d2    (d2),
      .sel   (sel),
      .y_nxt (y_nxt_s)
   );

   // Data register: load on valid samples only, otherwise keep the last result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_r <= {WIDTH{1'b0}};
      end else if (in_valid) begin
         y_r <= y_nxt_s;
      end else begin
         y_r <= y_r;
      end
   end

   // Valid qualifier follows in_valid with one cycle of latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= in_valid;
      end
   end

   assign y         = y_r;
   assign out_valid = out_valid_r;

`ifdef MUX3_TO_1_SELERR_EN
   logic       bad_evt_s;
   logic       sel_err_r;
   logic [7:0] err_cnt_r;

   assign bad_evt_s = in_valid & sel_is_bad(sel);

   // Sticky illegal-select flag; only reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_err_r <= 1'b0;
      end else if (bad_evt_s) begin
         sel_err_r <= 1'b1;
      end else begin
         sel_err_r <= sel_err_r;
      end
   end

   // Saturating illegal-select counter; stops at 255 instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_r <= 8'd0;
      end else if (bad_evt_s && (err_cnt_r != 8'hFF)) begin
         err_cnt_r <= err_cnt_r + 8'd1;
      end else begin
         err_cnt_r <= err_cnt_r;
      end
   end

   assign sel_err = sel_err_r;
   assign err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_mux3_to_1.sv
// ----------------------------------------------------------------------------
// tb_mux3_to_1
// Directed self-checking bench for mux3_to_1 (WIDTH = 16). Inputs are driven
// 1 ns after the rising edge and outputs are sampled 1 ns after the next one.
// Error-port checks are included when MUX3_TO_1_SELERR_EN is defined.
// ----------------------------------------------------------------------------
module tb_mux3_to_1;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [15:0] d0;
   logic [15:0] d1;
   logic [15:0] d2;
   logic [1:0]  sel;
   logic [15:0] y;
   logic        out_valid;
`ifdef MUX3_TO_1_SELERR_EN
   logic        sel_err;
   logic [7:0]  err_cnt;
`endif

   int total_cnt;
   int bad_cnt;

   mux3_to_1 #(
      .WIDTH (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .d0        (d0),
      .d1        (d1),
      .d2        (d2),
      .sel       (sel),
      .y         (y),
      .out_valid (out_valid)
`ifdef MUX3_TO_1_SELERR_EN
      ,
      .sel_err   (sel_err),
      .err_cnt   (err_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      if (obs !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic iv, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [1:0] s);
      in_valid = iv;
      d0       = a;
      d1       = b;
      d2       = c;
      sel      = s;
   endtask

   initial begin
      total_cnt = 0;
      bad_cnt   = 0;
      rst       = 1'b0;
      drive(1'b0, 16'h0000, 16'h0000, 16'h0000, 2'd0);

      // Asynchronous reset between edges
      #2 rst = 1'b1;
      #1;
      chk("rst_async_y",  {16'h0, y},          32'h0);
      chk("rst_async_ov", {31'h0, out_valid},  32'h0);
`ifdef MUX3_TO_1_SELERR_EN
      chk("rst_async_err", {31'h0, sel_err},   32'h0);
      chk("rst_async_cnt", {24'h0, err_cnt},   32'h0);
`endif
      step();
      chk("rst_held_ov", {31'h0, out_valid}, 32'h0);
      rst = 1'b0;
      step();
      chk("idle1_y",  {16'h0, y},         32'h0);
      chk("idle1_ov", {31'h0, out_valid}, 32'h0);
      step();
      chk("idle2_y",  {16'h0, y},         32'h0);
      chk("idle2_ov", {31'h0, out_valid}, 32'h0);

      // Select 1
      drive(1'b1, 16'h1100, 16'h001A, 16'h001A, 2'd1);
      step();
      chk("sel1_y",  {16'h0, y},         32'h001A);
      chk("sel1_ov", {31'h0, out_valid}, 32'h1);

      // Select 0 then 2 back-to-back
      drive(1'b1, 16'hFFFF, 16'h8976, 16'h1842, 2'd0);
      step();
      chk("sel0_y",  {16'h0, y},         32'hFFFF);
      chk("sel0_ov", {31'h0, out_valid}, 32'h1);
      drive(1'b1, 16'h1122, 16'h5656, 16'h1467, 2'd2);
      step();
      chk("sel2_y",  {16'h0, y},         32'h1467);
      chk("sel2_ov", {31'h0, out_valid}, 32'h1);

      // Hold: capture, then idle with changed data
      drive(1'b1, 16'h1111, 16'hABCD, 16'h2396, 2'd1);
      step();
      chk("hold_cap_y", {16'h0, y}, 32'hABCD);
      drive(1'b0, 16'h1111, 16'h0000, 16'h2396, 2'd1);
      #2;
      chk("hold_mid_y", {16'h0, y}, 32'hABCD);
      step();
      chk("hold_y",  {16'h0, y},         32'hABCD);
      chk("hold_ov", {31'h0, out_valid}, 32'h0);
      step();
      chk("hold2_y", {16'h0, y}, 32'hABCD);

      // Illegal select, then a legal one
      drive(1'b1, 16'h7777, 16'h4444, 16'hEEEE, 2'd3);
      step();
      chk("bad_y",  {16'h0, y},         32'h0000);
      chk("bad_ov", {31'h0, out_valid}, 32'h1);
`ifdef MUX3_TO_1_SELERR_EN
      chk("bad_err", {31'h0, sel_err},  32'h1);
      chk("bad_cnt", {24'h0, err_cnt},  32'h1);
`endif
      drive(1'b1, 16'h7777, 16'h4444, 16'hEEEE, 2'd0);
      step();
      chk("after_bad_y", {16'h0, y}, 32'h7777);
`ifdef MUX3_TO_1_SELERR_EN
      chk("sticky_err", {31'h0, sel_err}, 32'h1);
      chk("sticky_cnt", {24'h0, err_cnt}, 32'h1);
`endif

      // Reset mid-stream
      drive(1'b1, 16'h0000, 16'h0000, 16'h6890, 2'd2);
      step();
      chk("pre_rst_y", {16'h0, y}, 32'h6890);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_y",  {16'h0, y},         32'h0);
      chk("mid_rst_ov", {31'h0, out_valid}, 32'h0);
`ifdef MUX3_TO_1_SELERR_EN
      chk("mid_rst_err", {31'h0, sel_err},  32'h0);
      chk("mid_rst_cnt", {24'h0, err_cnt},  32'h0);
`endif
      step();
      rst = 1'b0;
      drive(1'b1, 16'h0BEE, 16'h0000, 16'h6890, 2'd0);
      step();
      chk("post_rst_y",  {16'h0, y},         32'h0BEE);
      chk("post_rst_ov", {31'h0, out_valid}, 32'h1);
      in_valid = 1'b0;
      step();
      chk("post_rst_idle_ov", {31'h0, out_valid}, 32'h0);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
